// File: rtl/pulse_gen.sv
// pulse_gen: turns single-cycle trigger strobes into timed level pulses
// with a guaranteed low gap, queuing early triggers in a saturating counter.
module pulse_gen #(
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned GAP_WIDTH   = 2,
  parameter int unsigned PENDING_MAX = 7,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic             clearOverflow,
  output logic             pulseOut,
  output logic             busy,
  output logic [7:0]       pending,
  output logic             overflow,
  output logic [CNT_W-1:0] pulseCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_GAP
  } state_t;

  localparam logic [7:0] HI_LOAD  = 8'(PULSE_WIDTH - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_WIDTH - 1);
  localparam logic [7:0] PEND_MAX = 8'(PENDING_MAX);

  if (PULSE_WIDTH < 1 || PULSE_WIDTH > 255 ||
      GAP_WIDTH < 1 || GAP_WIDTH > 255 ||
      PENDING_MAX < 1 || PENDING_MAX > 255) begin : g_bad_param
    $error("pulse_gen: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [7:0]       pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;

  logic at_end;
  logic start;
  logic pop;
  logic queue;
  logic drop;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    at_end  = (timer_q == 8'd0);
    start   = 1'b0;
    pop     = 1'b0;
    queue   = 1'b0;
    drop    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        start = trigger;
      end
      S_HIGH: begin
        queue = trigger;
        if (at_end) begin
          state_d = S_GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_GAP: begin
        if (!at_end) begin
          timer_d = timer_q - 8'd1;
          queue   = trigger;
        end else if (pend_q != 8'd0) begin
          pop   = 1'b1;
          start = 1'b1;
          queue = trigger;
        end else if (trigger) begin
          start = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 8'd0;
      end
    endcase

    if (start) begin
      state_d = S_HIGH;
      timer_d = HI_LOAD;
      cnt_d   = cnt_q + 1'b1;
    end

    // A push and a pop in the same cycle cancel, so saturation only drops
    // a trigger when nothing leaves the queue.
    drop = queue && !pop && (pend_q == PEND_MAX);
    if (queue && !pop && !drop) begin
      pend_d = pend_q + 8'd1;
    end else if (pop && !queue) begin
      pend_d = pend_q - 8'd1;
    end
  end

  assign ovf_d   = drop | (ovf_q & ~clearOverflow);
  assign pulse_d = (state_d == S_HIGH);
  assign busy_d  = (state_d != S_IDLE) || (pend_d != 8'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= 8'd0;
      pend_q  <= 8'd0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign pulseOut   = pulse_q;
  assign busy       = busy_q;
  assign pending    = pend_q;
  assign overflow   = ovf_q;
  assign pulseCount = cnt_q;

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed test-plan scenarios plus randomized triggers,
// checked by a cycle-arithmetic model through decoupled scoreboard queues.
module tb_pulse_gen;

  localparam int PW = 4;
  localparam int GW = 2;
  localparam int PM = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          trigger = 1'b0;
  logic          clearOverflow = 1'b0;
  logic          pulseOut;
  logic          busy;
  logic [7:0]    pending;
  logic          overflow;
  logic [CW-1:0] pulseCount;

  pulse_gen #(
    .PULSE_WIDTH(PW),
    .GAP_WIDTH(GW),
    .PENDING_MAX(PM),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .clearOverflow(clearOverflow),
    .pulseOut(pulseOut),
    .busy(busy),
    .pending(pending),
    .overflow(overflow),
    .pulseCount(pulseCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit po;
    bit bz;
    int pend;
    bit ovf;
    int cnt;
  } st_t;

  typedef struct {
    int start;
    int cnt;
  } pl_t;

  st_t stq[$];
  pl_t plq[$];

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
  endfunction

  // Reference model: one pulse occupies cycles [start, start+PW+GW-1];
  // a new pulse may begin only right after that window closes.
  bit m_act = 0;
  int m_start = 0;
  int m_pend = 0;
  bit m_ovf = 0;
  int m_cnt = 0;

  function automatic void m_begin(int s);
    m_act = 1;
    m_start = s;
    m_cnt = (m_cnt + 1) % (1 << CW);
    plq.push_back('{s, m_cnt});
  endfunction

  function automatic void m_step(int t, bit trg, bit clr);
    bit drop;
    bit at_end;
    bit pop;
    bit direct;
    bit q;
    drop = 0;
    if (!m_act) begin
      if (trg) m_begin(t + 1);
    end else begin
      at_end = (t == m_start + PW + GW - 1);
      pop = at_end && (m_pend > 0);
      direct = at_end && (m_pend == 0) && trg;
      q = trg && !direct;
      if (q && !pop) begin
        if (m_pend < PM) m_pend++;
        else drop = 1;
      end else if (pop && !q) begin
        m_pend--;
      end
      if (pop || direct) m_begin(t + 1);
      else if (at_end) m_act = 0;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    stq.push_back('{m_act && ((t + 1) < m_start + PW),
                    m_act, m_pend, m_ovf, m_cnt});
  endfunction

  // Monitor: compares every observed cycle and every pulse it sees.
  st_t e;
  pl_t p;
  int  hi = 0;
  bit  prev = 0;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      hi = 0;
      prev = 0;
    end else begin
      if (stq.size() > 0) begin
        e = stq.pop_front();
        chk("pulseOut", int'(pulseOut), int'(e.po));
        chk("busy", int'(busy), int'(e.bz));
        chk("pending", int'(pending), e.pend);
        chk("overflow", int'(overflow), int'(e.ovf));
        chk("pulseCount", int'(pulseCount), e.cnt);
      end
      if (pulseOut && !prev) begin
        if (plq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          p = plq.pop_front();
          chk("pulse_start", cyc, p.start);
          chk("pulse_cnt", int'(pulseCount), p.cnt);
        end
      end
      if (pulseOut) hi++;
      if (!pulseOut && prev) begin
        chk("pulse_width", hi, PW);
        hi = 0;
      end
      prev = pulseOut;
    end
  end

  task automatic drive(bit trg, bit clr);
    @(negedge clk);
    trigger = trg;
    clearOverflow = clr;
    m_step(cyc, trg, clr);
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0);
  endtask

  task automatic settle();
    int k;
    k = 0;
    while (m_act && k < 100) begin
      drive(0, 0);
      k++;
    end
    idle(2);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_pulseOut"}, int'(pulseOut), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pending"}, int'(pending), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_pulseCount"}, int'(pulseCount), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    trigger = 0;
    clearOverflow = 0;
    #1;
    chk_zero("async_rst");
    m_act = 0;
    m_pend = 0;
    m_ovf = 0;
    m_cnt = 0;
    stq.delete();
    plq.delete();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int dens;

  initial begin
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1;
    idle(4);

    // single trigger
    drive(1, 0);
    settle();

    // three back-to-back triggers
    repeat (3) drive(1, 0);
    settle();

    // saturate the queue and drop two
    repeat (6) drive(1, 0);
    settle();

    // trigger in the final gap cycle is taken directly
    drive(1, 0);
    idle(5);
    drive(1, 0);
    settle();

    // reset mid-pulse, then a clean pulse afterwards
    drive(1, 0);
    idle(1);
    do_reset();
    idle(2);
    drive(1, 0);
    settle();

    // clear collides with a drop, then a lone clear
    repeat (5) drive(1, 0);
    drive(1, 1);
    idle(3);
    drive(0, 1);
    idle(1);
    settle();

    // randomized bursts, with one reset in the middle
    dens = 30;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 5;
          1: dens = 30;
          2: dens = 70;
          default: dens = 100;
        endcase
      end
      if (i == 300) do_reset();
      drive($urandom_range(0, 99) < dens, $urandom_range(0, 99) < 3);
    end
    settle();

    @(posedge clk);
    #2;
    chk("stq_drained", stq.size(), 0);
    chk("plq_drained", plq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
